alu_seq_unit: RTL
=================

Name: alu_seq_unit

Overview:
- Parametrised, handshaked successor to the single-cycle 32-bit ALU in the MIPS datapath.
- Adds WIDTH generalisation and registered outputs with valid/ready flow control.
- Adds iterative unsigned multiply and divide that return a double-width result.
- Serves the planned multi-cycle datapath: the control FSM issues one operation and stalls until the result is consumed.

Parameters:
- WIDTH, 32, operand/result width; legal values 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- op  in  4  opcode (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res_lo  out  WIDTH  result; quotient for DIVU
- res_hi  out  WIDTH  MULU upper product, DIVU remainder, 0 otherwise
- c_out  out  1  carry out
- v  out  1  overflow / exception flag
- z  out  1  res_lo == 0

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed).
  - 1000 MULU, 1001 DIVU.
  - Any other code is undefined: res_lo = 0, res_hi = 0, c_out = 0, v = 0, z = 1; completes as a 1-cycle op.
- Reset (async, rst_n low): state IDLE; in_ready 0 while rst_n low, 1 after release; out_valid, res_lo, res_hi, c_out, v, z all 0. Reset mid-operation discards the operation; no partial result is ever presented.
- FSM:
  - IDLE: in_ready = 1. Accept when in_valid & in_ready. Base/undefined op: go to DONE. MULU/DIVU: go to BUSY, cnt = 0.
  - BUSY: in_ready = 0. One iteration per clock; cnt increments. On iteration cnt == WIDTH-1, go to DONE with the final result.
  - DONE: out_valid = 1, in_ready = 0. When out_ready = 1, go to IDLE. Outputs are held stable while out_ready = 0.
- Latency, for a request accepted in cycle N:
  - Base ops: out_valid in cycle N+1.
  - MULU/DIVU: out_valid in cycle N+1+WIDTH.
  - Back-to-back: a new request can be accepted at the earliest in the cycle after the out_valid & out_ready handshake. No overlap.
- Operands are captured at accept; a, b and op are ignored at all other times.
- Arithmetic:
  - ADD: {c_out, res_lo} = a + b. v = signed overflow (a[MSB] == b[MSB] and res[MSB] != a[MSB]).
  - SUB: a + ~b + 1. c_out = carry out, so 1 means no borrow. v = signed overflow.
  - SLT: res_lo = {0, sub_msb ^ sub_v}. c_out and v come from the internal subtraction.
  - AND/OR: c_out = 0, v = 0.
  - MULU: shift-add over a 2*WIDTH product register. v = (res_hi != 0). c_out = 0.
  - DIVU: restoring division. If b == 0: res_lo = all ones, res_hi = a, v = 1, still WIDTH cycles. c_out = 0.
  - z is always computed on res_lo only.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIVU is implemented as specified; the remainder datapath and divide-by-zero handling are present.
- Undefined: divider logic is absent; opcode 1001 behaves as an undefined opcode (1-cycle, zero result, z = 1). MULU is unaffected.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULU, OP_DIVU); FSM state encoding ST_IDLE / ST_BUSY / ST_DONE (2 bits).
- One sub-module: alu_comb_core. Combinational WIDTH-parametrised AND/OR/ADD/SUB/SLT with c_out/v/z; its outputs are registered by the parent.
- Multiply/divide iteration and the FSM stay in alu_seq_unit. MULU and DIVU share one 2*WIDTH shift register.

Test Plan:
- WIDTH = 32, AND, a = AAAAAAAA, b = 55555555 -> res_lo = 0, z = 1, out_valid 1 cycle after accept. Same operands with OR -> FFFFFFFF, z = 0.
- ADD 12 + 10 -> 22. ADD FFFFFFFF + FFFFFFFF -> FFFFFFFE, c_out = 1, v = 0. ADD 7FFFFFFF + 1 -> v = 1. SUB 12 - 12 -> 0, z = 1, c_out = 1.
- SLT a = 0, b = FFFFFFFF -> res_lo = 0. SLT a = FFFFFFFF, b = 0 -> res_lo = 1. Undefined op 0011 -> res_lo = 0, z = 1.
- MULU 00010000 * 00010000 -> res_lo = 0, res_hi = 1, v = 1, z = 1; out_valid exactly 33 cycles after accept; in_ready = 0 throughout.
- DIVU 100 / 7 -> res_lo = 14, res_hi = 2, v = 0. DIVU 5 / 0 -> res_lo = FFFFFFFF, res_hi = 5, v = 1. Without ALU_SEQ_DIV_EN: res_lo = 0, z = 1, 1-cycle.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0. Assert rst_n = 0 mid-MULU -> all outputs 0 immediately; next op after release completes correctly. Repeat ADD/MULU tests with WIDTH = 8.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and op classification for alu_seq_unit.
// Optional divider: define ALU_SEQ_DIV_EN to build the DIVU datapath.
package alu_seq_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ops that run through the shared iterative shift register.
   function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      return (op == OP_MULU) || (op == OP_DIVU);
`else
      return (op == OP_MULU);
`endif
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle AND/OR/ADD/SUB/SLT datapath with carry, overflow and zero flags.
// Unknown opcodes (including MULU/DIVU) give a zero result with clear flags.
module alu_comb_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o,
   output logic             c_o,
   output logic             v_o,
   output logic             z_o
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0] add_w;
   logic [WIDTH:0] sub_w;
   logic           add_v;
   logic           sub_v;

   assign add_w = {1'b0, a_i} + {1'b0, b_i};
   assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);

   // Signed overflow: operands agree (add) or differ (sub) in sign and the result flips it.
   assign add_v = (a_i[MSB] == b_i[MSB]) && (add_w[MSB] != a_i[MSB]);
   assign sub_v = (a_i[MSB] != b_i[MSB]) && (sub_w[MSB] != a_i[MSB]);

   always_comb begin
      res_o = '0;
      c_o   = 1'b0;
      v_o   = 1'b0;
      case (op_i)
         OP_AND: res_o = a_i & b_i;
         OP_OR:  res_o = a_i | b_i;
         OP_ADD: begin
            res_o = add_w[MSB:0];
            c_o   = add_w[WIDTH];
            v_o   = add_v;
         end
         OP_SUB: begin
            res_o = sub_w[MSB:0];
            c_o   = sub_w[WIDTH];
            v_o   = sub_v;
         end
         OP_SLT: begin
            res_o = {{(WIDTH-1){1'b0}}, sub_w[MSB] ^ sub_v};
            c_o   = sub_w[WIDTH];
            v_o   = sub_v;
         end
         default: begin
            res_o = '0;
            c_o   = 1'b0;
            v_o   = 1'b0;
         end
      endcase
   end

   assign z_o = ~|res_o;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: 1-cycle base ops, WIDTH-cycle unsigned multiply/divide, registered outputs.
// Define ALU_SEQ_DIV_EN to include DIVU; otherwise opcode 1001 acts as undefined.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             c_out,
   output logic             v,
   output logic             z
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int W2    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] opnd_q;
   logic [W2-1:0]    sh_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] res_lo_q;
   logic [WIDTH-1:0] res_hi_q;
   logic             c_q;
   logic             v_q;
   logic             z_q;

   logic [WIDTH-1:0] core_res;
   logic             core_c;
   logic             core_v;
   logic             core_z;

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .op_i  (op),
      .a_i   (a),
      .b_i   (b),
      .res_o (core_res),
      .c_o   (core_c),
      .v_o   (core_v),
      .z_o   (core_z)
   );

   // Multiply step: sh_q = {partial product, remaining multiplier}; opnd_q = multiplicand.
   logic [WIDTH:0]  mul_sum;
   logic [W2-1:0]   mul_next;
   logic [W2-1:0]   step_d;

   assign mul_sum  = {1'b0, sh_q[W2-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_next = sh_q[0] ? {mul_sum, sh_q[WIDTH-1:1]} : {1'b0, sh_q[W2-1:1]};

`ifdef ALU_SEQ_DIV_EN
   // Restoring divide: sh_q = {partial remainder, dividend/quotient}; opnd_q = divisor.
   logic             mul_q;
   logic [WIDTH:0]   div_rem;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [W2-1:0]    div_next;

   assign div_rem  = {sh_q[W2-1:WIDTH], sh_q[WIDTH-1]};
   assign div_ge   = (div_rem >= {1'b0, opnd_q});
   assign div_sub  = div_rem[WIDTH-1:0] - opnd_q;
   assign div_next = div_ge ? {div_sub, sh_q[WIDTH-2:0], 1'b1}
                            : {div_rem[WIDTH-1:0], sh_q[WIDTH-2:0], 1'b0};
   assign step_d   = mul_q ? mul_next : div_next;
`else
   assign step_d   = mul_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         opnd_q      <= '0;
         sh_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         res_lo_q    <= '0;
         res_hi_q    <= '0;
         c_q         <= 1'b0;
         v_q         <= 1'b0;
         z_q         <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         mul_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  if (is_iter_op(op)) begin
                     state_q <= ST_BUSY;
                     cnt_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
                     mul_q   <= (op == OP_MULU);
                     opnd_q  <= (op == OP_MULU) ? a : b;
                     sh_q    <= {{WIDTH{1'b0}}, ((op == OP_MULU) ? b : a)};
`else
                     opnd_q  <= a;
                     sh_q    <= {{WIDTH{1'b0}}, b};
`endif
                  end else begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b1;
                     res_lo_q    <= core_res;
                     res_hi_q    <= '0;
                     c_q         <= core_c;
                     v_q         <= core_v;
                     z_q         <= core_z;
                  end
               end
            end
            ST_BUSY: begin
               sh_q  <= step_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
                  res_lo_q    <= step_d[WIDTH-1:0];
                  res_hi_q    <= step_d[W2-1:WIDTH];
                  c_q         <= 1'b0;
                  z_q         <= ~|step_d[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
                  v_q         <= mul_q ? (|step_d[W2-1:WIDTH]) : (opnd_q == '0);
`else
                  v_q         <= |step_d[W2-1:WIDTH];
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign res_lo    = res_lo_q;
   assign res_hi    = res_hi_q;
   assign c_out     = c_q;
   assign v         = v_q;
   assign z         = z_q;

endmodule
